dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the processor's single data-memory port (address, write data, write enable, read data) between requester 0 (processor load/store path) and requester 1 (DMA/debug loader). Transfers are single-word, one per cycle, with a zero-cycle grant and round-robin fairness. A lock mechanism keeps the port with one requester for atomic read-modify-write sequences, and a timeout bounds how long a lock can hold it. The block sits between both requesters and the synchronous data memory.

## Interface
- AW, 32, address width
- DW, 32, data width
- LOCK_MAX, 16, maximum consecutive cycles a lock may hold the port (>=2)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- r0_req, r1_req  in  1  transfer request from requester 0 / 1
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_lock, r1_lock  in  1  request exclusive ownership after this grant
- r0_addr, r1_addr  in  AW  word address
- r0_wdata, r1_wdata  in  DW  write data
- r0_gnt, r1_gnt  out  1  transfer accepted this cycle (combinational)
- r0_rvalid, r1_rvalid  out  1  read data valid (registered)
- r0_rdata, r1_rdata  out  DW  read data; 0 when the matching rvalid is low
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after the address is presented

## Operation
- Handshake: a transfer completes in any cycle where rX_req and rX_gnt are both high. A requester holds req, we, addr and wdata stable until it is granted. At most one gnt is high per cycle.
- The selected port's addr, wdata and we drive the memory outputs through a mux. mem_we = gnt & we of the selected port.
- When no port is granted: mem_we=0, and mem_addr/mem_wdata are 0.
- State machine states: IDLE, LOCK0, LOCK1.
  - IDLE, single request: that port is granted.
  - IDLE, both requesting: the port other than `last` is granted. `last` resets to 1, so port 0 wins the first tie.
  - IDLE to LOCKx: on a grant to port x with rx_lock=1 and lock_blk_x=0.
  - LOCKx: only port x can be granted; the other port's gnt=0 even if it requests.
  - LOCKx to IDLE: on the first cycle where rx_lock=0, sampled whether or not req is high.
  - LOCKx timeout: the cycle counter clears on entry and increments every cycle in LOCKx. When counter == LOCK_MAX-1, the next state is IDLE regardless of lock. On timeout, set last=x and lock_blk_x=1.
  - lock_blk_x clears on the first cycle rx_lock=0. While lock_blk_x is set, port x is arbitrated normally but cannot re-enter LOCKx.
- `last` updates to the granted port index on every grant, in every state.
- Read response: rX_rvalid <= rX_gnt & ~rX_we. rX_rdata = mem_rdata while rX_rvalid=1, else 0.
- Writes produce no rvalid.

## Timing
- Grant latency is 0 cycles (combinational from req and state).
- Read data returns 1 cycle after grant. Throughput is 1 transfer per cycle, and back-to-back transfers from either port are allowed.
- Alternating reads (r0 then r1) yield r0_rvalid and r1_rvalid on consecutive cycles with no bubble.
- Reset asserted, asynchronously:
  - state=IDLE, last=1, counter=0, lock_blk_0/1=0, rvalid=0;
  - gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
  - These values hold for as long as reset is low.
- Reset mid-read: the pending rvalid is dropped and never asserted.
- The first grant can occur in the cycle after reset deasserts.
- A request during reset is treated as a new request after release. No request is remembered across reset.
- In the same cycle as entering LOCKx, the other port is not granted.
- The exit cycle from LOCKx still grants by LOCKx rules. IDLE rules apply from the next cycle.
- Counter width is clog2(LOCK_MAX). The counter must not wrap before the timeout fires.

## Test plan
- Reset then single access: reset low 3 cycles, then release. r0 reads addr 0x10 with mem returning 0xDEADBEEF. Required: r0_gnt=1 in the same cycle, r0_rvalid=1 and r0_rdata=0xDEADBEEF one cycle later, r1 signals stay 0.
- Round-robin tie: both ports request reads continuously for 4 cycles. Required grant order 0,1,0,1, with rvalid alternating one cycle behind each grant.
- Write path: r1 writes 0x0000_00AA to 0x20. Required: mem_we=1, mem_addr=0x20, mem_wdata=0xAA in the grant cycle, and no r1_rvalid.
- Lock: r0 reads 0x40 with lock=1, then writes 0x40 with lock=0 two cycles later while r1 requests throughout. Required: r1_gnt=0 until the cycle after r0_lock drops, then r1 is granted.
- Lock timeout: r0 holds lock=1 and req=1 forever with LOCK_MAX=16 while r1 requests. Required: r1 is granted 17 cycles after the lock grant, r0 never re-enters LOCK0 until its lock drops, and r0/r1 then alternate.
- Reset mid-read: r1 is granted a read, and reset goes low before the next edge. Required: r1_rvalid stays 0, and all outputs read 0 while reset is low.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares one synchronous data-memory port between requester 0
//             (processor load/store) and requester 1 (DMA / debug loader).
//             Single-word transfers, zero-cycle combinational grant,
//             round-robin on ties, lock for atomic sequences with a timeout.
//  Ports    : clk, reset (async, active-low)
//             rX_req/we/lock/addr/wdata  requester X transfer request
//             rX_gnt                     transfer accepted this cycle (comb)
//             rX_rvalid/rdata            read response, one cycle after grant
//             mem_we/addr/wdata          memory request (muxed, 0 when idle)
//             mem_rdata                  memory read data (1-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            CW       = $clog2(LOCK_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          blk0_q, blk0_d;
  logic          blk1_q, blk1_d;
  logic          rv0_q, rv1_q;
  logic          gnt0, gnt1;
  logic          to0, to1;

  // Next-state, grant and bookkeeping logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    to0     = 1'b0;
    to1     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the port that did not win last time goes first
        if (r0_req && r1_req) begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end else begin
          gnt0 = r0_req;
          gnt1 = r1_req;
        end
        if (gnt0 && r0_lock && !blk0_q) begin
          state_d = ST_LOCK0;
        end else if (gnt1 && r1_lock && !blk1_q) begin
          state_d = ST_LOCK1;
        end
      end
      ST_LOCK0: begin
        gnt0 = r0_req;
        if (cnt_q == CNT_LAST) begin
          to0     = 1'b1;
          state_d = ST_IDLE;
        end else if (!r0_lock) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOCK1: begin
        gnt1 = r1_req;
        if (cnt_q == CNT_LAST) begin
          to1     = 1'b1;
          state_d = ST_IDLE;
        end else if (!r1_lock) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
    if (to0) last_d = 1'b0;
    if (to1) last_d = 1'b1;

    // A timed-out lock may not re-lock until its owner lets go of lock once
    blk0_d = blk0_q;
    if (!r0_lock) begin
      blk0_d = 1'b0;
    end else if (to0) begin
      blk0_d = 1'b1;
    end
    blk1_d = blk1_q;
    if (!r1_lock) begin
      blk1_d = 1'b0;
    end else if (to1) begin
      blk1_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      blk0_q  <= 1'b0;
      blk1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      blk0_q  <= blk0_d;
      blk1_q  <= blk1_d;
      rv0_q   <= gnt0 & ~r0_we;
      rv1_q   <= gnt1 & ~r1_we;
    end
  end

  // Grants are forced low combinationally while reset is held
  assign r0_gnt = gnt0 & reset;
  assign r1_gnt = gnt1 & reset;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r0_gnt) begin
      mem_we    = r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (r1_gnt) begin
      mem_we    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  assign r0_rvalid = rv0_q;
  assign r1_rvalid = rv1_q;
  assign r0_rdata  = rv0_q ? mem_rdata : '0;
  assign r1_rdata  = rv1_q ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. A behavioural model of
//             ownership, fairness and read responses is compared with the
//             DUT every cycle; directed scenarios add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : (32'h1000_0000 + {24'h0, a});
  endfunction

  // ---------------- bench memory (driven by DUT memory port) ---------------
  logic [31:0] b_mem [0:255];
  bit          b_wr  [0:255];
  always @(posedge clk) begin
    if (mem_we) begin
      b_mem[mem_addr[7:0]] <= mem_wdata;
      b_wr[mem_addr[7:0]]  <= 1'b1;
    end
    mem_rdata <= b_wr[mem_addr[7:0]] ? b_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  end

  // ---------------- behavioural model ---------------------------------------
  // owner: -1 = port free, else index of the port holding a lock
  // held : number of locked cycles the owner has had so far
  int          m_owner;
  int          m_held;
  bit          m_blk0, m_blk1, m_last;
  bit          m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] m_mem [0:255];
  bit          m_wr  [0:255];
  logic        m_g0, m_g1;

  always_comb begin
    m_g0 = 1'b0;
    m_g1 = 1'b0;
    if (reset === 1'b1) begin
      if (m_owner == 0) begin
        m_g0 = r0_req;
      end else if (m_owner == 1) begin
        m_g1 = r1_req;
      end else if (r0_req && r1_req) begin
        m_g0 = m_last;
        m_g1 = !m_last;
      end else begin
        m_g0 = r0_req;
        m_g1 = r1_req;
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= -1;
      m_held  <= 0;
      m_blk0  <= 1'b0;
      m_blk1  <= 1'b0;
      m_last  <= 1'b1;
      m_rv0   <= 1'b0;
      m_rv1   <= 1'b0;
      m_rd0   <= 32'h0;
      m_rd1   <= 32'h0;
    end else begin
      m_rv0 <= m_g0 && !r0_we;
      m_rv1 <= m_g1 && !r1_we;
      m_rd0 <= m_wr[r0_addr[7:0]] ? m_mem[r0_addr[7:0]] : init_val(r0_addr[7:0]);
      m_rd1 <= m_wr[r1_addr[7:0]] ? m_mem[r1_addr[7:0]] : init_val(r1_addr[7:0]);
      if (m_g0 && r0_we) begin
        m_mem[r0_addr[7:0]] <= r0_wdata;
        m_wr[r0_addr[7:0]]  <= 1'b1;
      end
      if (m_g1 && r1_we) begin
        m_mem[r1_addr[7:0]] <= r1_wdata;
        m_wr[r1_addr[7:0]]  <= 1'b1;
      end
      if (m_g0) m_last <= 1'b0;
      else if (m_g1) m_last <= 1'b1;
      if (!r0_lock) m_blk0 <= 1'b0;
      if (!r1_lock) m_blk1 <= 1'b0;
      if (m_owner == -1) begin
        if (m_g0 && r0_lock && !m_blk0) begin
          m_owner <= 0;
          m_held  <= 1;
        end else if (m_g1 && r1_lock && !m_blk1) begin
          m_owner <= 1;
          m_held  <= 1;
        end
      end else if (m_owner == 0) begin
        if (!r0_lock) m_owner <= -1;
        else if (m_held == LOCK_MAX) begin
          m_owner <= -1;
          m_blk0  <= 1'b1;
          m_last  <= 1'b0;
        end else m_held <= m_held + 1;
      end else begin
        if (!r1_lock) m_owner <= -1;
        else if (m_held == LOCK_MAX) begin
          m_owner <= -1;
          m_blk1  <= 1'b1;
          m_last  <= 1'b1;
        end else m_held <= m_held + 1;
      end
    end
  end

  // ---------------- per-cycle comparison ------------------------------------
  always @(negedge clk) begin
    chk("r0_gnt", r0_gnt, m_g0);
    chk("r1_gnt", r1_gnt, m_g1);
    chk("mem_we", mem_we, m_g0 ? r0_we : (m_g1 ? r1_we : 1'b0));
    chk("mem_addr", mem_addr, m_g0 ? r0_addr : (m_g1 ? r1_addr : 32'h0));
    chk("mem_wdata", mem_wdata, m_g0 ? r0_wdata : (m_g1 ? r1_wdata : 32'h0));
    chk("r0_rvalid", r0_rvalid, m_rv0);
    chk("r1_rvalid", r1_rvalid, m_rv1);
    chk("r0_rdata", r0_rdata, m_rv0 ? m_rd0 : 32'h0);
    chk("r1_rdata", r1_rdata, m_rv1 ? m_rd1 : 32'h0);
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic drv0(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wdata);
    r0_req = req; r0_we = we; r0_lock = lock; r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wdata);
    r1_req = req; r1_we = we; r1_lock = lock; r1_addr = addr; r1_wdata = wdata;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first_r1;
    int   n_r0;
    logic exp_order [4];
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    // Reset with r0 already requesting: nothing may be granted
    reset = 1'b0;
    drv0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      @(negedge clk);
      chk("rst_r0_gnt", r0_gnt, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_r0_rvalid", r0_rvalid, 1'b0);
    end

    // Single read after release
    nxt();
    reset = 1'b1;
    @(negedge clk);
    chk("t1_r0_gnt", r0_gnt, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    nxt();
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_r0_rvalid", r0_rvalid, 1'b1);
    chk("t1_r0_rdata", r0_rdata, 32'hDEADBEEF);
    chk("t1_r1_rvalid", r1_rvalid, 1'b0);

    // r1 write
    nxt();
    drv1(1'b1, 1'b1, 1'b0, 32'h20, 32'hAA);
    @(negedge clk);
    chk("wr_r1_gnt", r1_gnt, 1'b1);
    chk("wr_mem_we", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 32'h20);
    chk("wr_mem_wdata", mem_wdata, 32'hAA);
    nxt();
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("wr_r1_rvalid", r1_rvalid, 1'b0);

    // Round-robin tie, four continuous cycles
    nxt();
    drv0(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nxt();
      if (k == 4) begin
        drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      @(negedge clk);
      if (k < 4) chk("rr_gnt", {r1_gnt, r0_gnt}, exp_order[k] ? 2'b10 : 2'b01);
      if (k > 0) chk("rr_rvalid", {r1_rvalid, r0_rvalid}, exp_order[k-1] ? 2'b10 : 2'b01);
      if (k == 1) chk("rr_r0_rdata", r0_rdata, 32'hAA);
    end

    // Lock held by r0 over a read-modify-write while r1 waits
    nxt();
    drv0(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
    first_r1 = -1;
    for (int t = 0; t < 5; t++) begin
      if (t > 0) nxt();
      if (t == 1) drv0(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
      if (t == 2) drv0(1'b1, 1'b1, 1'b0, 32'h40, 32'h41);
      if (t == 3) drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      if (r1_gnt && first_r1 < 0) first_r1 = t;
      if (t == 0) chk("lk_r0_gnt0", r0_gnt, 1'b1);
      if (t == 2) chk("lk_r0_gnt2", {r0_gnt, mem_we}, 2'b11);
    end
    chk("lk_first_r1", first_r1, 3);
    nxt();
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Lock timeout: r0 never releases its lock
    nxt();
    drv0(1'b1, 1'b0, 1'b1, 32'h60, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'h70, 32'h0);
    first_r1 = -1;
    n_r0     = 0;
    for (int t = 0; t < 25; t++) begin
      if (t > 0) nxt();
      @(negedge clk);
      if (r1_gnt && first_r1 < 0) first_r1 = t;
      if (t <= 16 && r0_gnt) n_r0++;
      if (t == 18) chk("to_r0_gnt18", r0_gnt, 1'b1);
      if (t == 19) chk("to_r1_gnt19", r1_gnt, 1'b1);
      if (t == 20) chk("to_r0_gnt20", r0_gnt, 1'b1);
    end
    chk("to_first_r1", first_r1, 17);
    chk("to_r0_count", n_r0, 17);
    nxt();
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset asserted between an r1 read grant and its response
    nxt();
    drv1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rm_r1_gnt", r1_gnt, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("rm_r1_gnt_rst", r1_gnt, 1'b0);
    chk("rm_mem_addr_rst", mem_addr, 32'h0);
    chk("rm_mem_we_rst", mem_we, 1'b0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      @(negedge clk);
      chk("rm_r1_rvalid", r1_rvalid, 1'b0);
      chk("rm_r1_rdata", r1_rdata, 32'h0);
    end
    nxt();
    reset = 1'b1;
    @(negedge clk);
    chk("rm_r1_gnt_rel", r1_gnt, 1'b1);
    nxt();
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rm_r1_rvalid_rel", r1_rvalid, 1'b1);
    chk("rm_r1_rdata_rel", r1_rdata, 32'hDEADBEEF);
    nxt();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
